// File: rtl/vga_scanout.sv
// VGA raster timing generator that fetches pixels from a framebuffer and
// re-times sync/enable so they line up with the returning pixel data.
module vga_scanout #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int HS_POL      = 0,
    parameter int VS_POL      = 0,
    parameter int RGB_W       = 3,
    parameter int ADDR_W      = 19,
    parameter int FB_LAT      = 1,
    parameter int SCALE_SHIFT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [9:0]        line_cmp,
    output logic              fb_rd_en,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [RGB_W-1:0]  fb_rdata,
    output logic [RGB_W-1:0]  rgb,
    output logic              hs,
    output logic              vs,
    output logic              de,
    output logic              vblank,
    output logic              frame_start,
    output logic              line_irq,
    output logic [15:0]       frame_cnt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DEPTH   = FB_LAT + 1;

    localparam logic [31:0] HA       = 32'(H_ACTIVE);
    localparam logic [31:0] VA       = 32'(V_ACTIVE);
    localparam logic [31:0] HS_START = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] VS_START = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [31:0] H_LAST   = 32'(H_TOTAL - 1);
    localparam logic [31:0] V_LAST   = 32'(V_TOTAL - 1);
    localparam logic [31:0] H_SCALED = 32'(H_ACTIVE >> SCALE_SHIFT);
    localparam logic        HS_ON    = (HS_POL != 0);
    localparam logic        VS_ON    = (VS_POL != 0);

    logic [HW-1:0]     hx_q, hx_d;
    logic [VW-1:0]     vy_q, vy_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic [DEPTH-1:0]  de_pipe_q, hs_pipe_q, vs_pipe_q;
    logic [RGB_W-1:0]  rgb_q;

    logic [31:0]       hx_w, vy_w;
    logic [ADDR_W-1:0] addr_full;
    logic              h_last, v_last, active, hs_raw, vs_raw;

    always_comb begin
        hx_w      = 32'(hx_q);
        vy_w      = 32'(vy_q);
        h_last    = (hx_w == H_LAST);
        v_last    = (vy_w == V_LAST);
        active    = (hx_w < HA) && (vy_w < VA);
        hs_raw    = (hx_w >= HS_START) && (hx_w < HS_END);
        vs_raw    = (vy_w >= VS_START) && (vy_w < VS_END);
        addr_full = ADDR_W'((vy_w >> SCALE_SHIFT) * H_SCALED + (hx_w >> SCALE_SHIFT));
    end

    // Raster position: parked at the origin whenever scanout is stopped.
    always_comb begin
        hx_d        = hx_q;
        vy_d        = vy_q;
        frame_cnt_d = frame_cnt_q;
        if (!enable) begin
            hx_d = '0;
            vy_d = '0;
        end else if (h_last) begin
            hx_d = '0;
            vy_d = v_last ? '0 : vy_q + VW'(1);
            if (v_last) begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        end else begin
            hx_d = hx_q + HW'(1);
        end
    end

    // Read contract: fb_addr is sampled with fb_rd_en, and the memory returns
    // that pixel on fb_rdata exactly FB_LAT clocks later with no back-pressure.
    assign fb_rd_en    = active && enable && !reset;
    assign fb_addr     = active ? addr_full : '0;
    assign vblank      = !reset && (vy_w >= VA);
    assign frame_start = !reset && enable && (hx_q == '0) && (vy_q == '0);
    assign line_irq    = !reset && (hx_w == HA) && (vy_w == 32'(line_cmp));

    always_ff @(posedge clk) begin
        if (reset) begin
            hx_q        <= '0;
            vy_q        <= '0;
            frame_cnt_q <= '0;
            de_pipe_q   <= '0;
            hs_pipe_q   <= {DEPTH{~HS_ON}};
            vs_pipe_q   <= {DEPTH{~VS_ON}};
            rgb_q       <= '0;
        end else begin
            hx_q        <= hx_d;
            vy_q        <= vy_d;
            frame_cnt_q <= frame_cnt_d;
            de_pipe_q   <= {de_pipe_q[DEPTH-2:0], fb_rd_en};
            hs_pipe_q   <= {hs_pipe_q[DEPTH-2:0], hs_raw ? HS_ON : ~HS_ON};
            vs_pipe_q   <= {vs_pipe_q[DEPTH-2:0], vs_raw ? VS_ON : ~VS_ON};
            // Stage FB_LAT-1 marks the cycle the fetched pixel is on fb_rdata.
            rgb_q       <= de_pipe_q[FB_LAT-1] ? fb_rdata : '0;
        end
    end

    assign rgb       = rgb_q;
    assign de        = de_pipe_q[FB_LAT];
    assign hs        = hs_pipe_q[FB_LAT];
    assign vs        = vs_pipe_q[FB_LAT];
    assign frame_cnt = frame_cnt_q;

endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 SHALL take parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL take parameter H_FP, default 16, horizontal front porch in clocks.
REQ-003 SHALL take parameter H_SYNC, default 96, horizontal sync width in clocks.
REQ-004 SHALL take parameter H_BP, default 48, horizontal back porch in clocks; H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
REQ-005 SHALL take parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 SHALL take parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL take parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 SHALL take parameter V_BP, default 33, vertical back porch in lines; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-009 SHALL take parameter HS_POL, default 0, hs asserted level (0 = active-low).
REQ-010 SHALL take parameter VS_POL, default 0, vs asserted level.
REQ-011 SHALL take parameter RGB_W, default 3, pixel width.
REQ-012 SHALL take parameter ADDR_W, default 19, framebuffer address width.
REQ-013 SHALL take parameter FB_LAT, default 1, framebuffer read latency in clocks (>=1).
REQ-014 SHALL take parameter SCALE_SHIFT, default 0, pixel/line replication factor 2^SCALE_SHIFT (0..3).
REQ-015 SHALL have port clk, input, 1, pixel clock; sole clock of the block.
REQ-016 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-017 SHALL have port enable, input, 1, scanout run; 0 holds timing at origin.
REQ-018 SHALL have port line_cmp, input, 10, line number for line_irq.
REQ-019 SHALL have port fb_rd_en, output, 1, framebuffer read strobe.
REQ-020 SHALL have port fb_addr, output, ADDR_W, framebuffer read address.
REQ-021 SHALL have port fb_rdata, input, RGB_W, data valid FB_LAT clocks after fb_rd_en.
REQ-022 SHALL have ports rgb (RGB_W), hs, vs, de (1 each), outputs, aligned video.
REQ-023 SHALL have ports vblank, frame_start, line_irq (1 each) and frame_cnt (16), outputs, status.

Function
REQ-024 hx SHALL count 0..H_TOTAL-1, wrap to 0; vy SHALL increment when hx wraps, count 0..V_TOTAL-1, wrap to 0.
REQ-025 enable=0 SHALL force hx=vy=0 and hold; fb_rd_en=0; the delayed pipeline keeps shifting, so outputs drain to blank.
REQ-026 Active region SHALL be hx<H_ACTIVE and vy<V_ACTIVE; fb_rd_en SHALL equal active AND enable, combinationally from counters.
REQ-027 fb_addr SHALL be (vy>>SCALE_SHIFT)*(H_ACTIVE>>SCALE_SHIFT)+(hx>>SCALE_SHIFT), truncated to ADDR_W; 0 outside active region.
REQ-028 Raw hs SHALL be asserted for H_ACTIVE+H_FP <= hx < H_ACTIVE+H_FP+H_SYNC; raw vs for V_ACTIVE+V_FP <= vy < V_ACTIVE+V_FP+V_SYNC; levels per HS_POL/VS_POL.
REQ-029 hs, vs, de SHALL be raw hs, vs, active delayed through a FB_LAT+1 stage register chain; rgb SHALL be registered fb_rdata when the stage-FB_LAT de is 1, else 0.
REQ-030 Pixel at counter (x,y) SHALL appear on rgb exactly FB_LAT+1 clocks after counters equal (x,y), coincident with its de, hs, vs.
REQ-031 vblank SHALL be 1 while vy>=V_ACTIVE (undelayed, counter-aligned).
REQ-032 frame_start SHALL pulse one clock when enable=1 and hx=0, vy=0 (counter-aligned).
REQ-033 line_irq SHALL pulse one clock when hx=H_ACTIVE and vy=line_cmp; line_cmp>=V_TOTAL SHALL never fire.
REQ-034 frame_cnt SHALL increment when hx=H_TOTAL-1 and vy=V_TOTAL-1, wrap 0xFFFF->0.
REQ-035 frame_start and line_irq SHALL both fire in the same cycle if coincident (H_ACTIVE=0 not supported).

Reset
REQ-036 reset SHALL clear hx, vy, frame_cnt, all pipeline stages; rgb=0, de=0, hs=~HS_POL, vs=~VS_POL, fb_rd_en=0, frame_start=0, line_irq=0, vblank=0.
REQ-037 reset SHALL override enable; reset mid-frame SHALL restart at (0,0) the first clock after deassertion, with frame_start pulsing that clock if enable=1.

Verification
REQ-038 Defaults, enable=1, fb_rdata=addr[2:0]: hs low 96 clocks, period 800; vs low 1600 clocks, period 420000.
REQ-039 Defaults: fb_rd_en at addr 0 in cycle t -> de=1, rgb=0 at t+2; addr 639 -> rgb=7 at t+641; de=0 at t+642.
REQ-040 SCALE_SHIFT=1: hx=0..3 on vy=0,1 -> fb_addr 0,0,1,1 on both lines; vy=2 -> fb_addr 320.
REQ-041 line_cmp=5: exactly one line_irq per frame at hx=640, vy=5; line_cmp=600: none over 2 frames.
REQ-042 reset pulse at hx=300, vy=200: next clock all outputs at reset values; counters restart at 0, frame_cnt=0.
REQ-043 FB_LAT=3, HS_POL=1: hs high 96 clocks, rgb/de/hs delayed 4 clocks; enable dropped mid-line -> de=0 within 4 clocks.
